// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the SDRAM port arbiter.
// Imported by the arbiter top and its read tracker.
package sdram_arb_pkg;

    localparam int ARB_ADDR_W  = 27;
    localparam int ARB_DATA_W  = 256;
    localparam int ARB_BURST_W = 8;

    typedef enum logic {
        GNT_W,
        GNT_R
    } gnt_t;

endpackage

// File: rtl/sdram_arb_rd_tracker.sv
// Outstanding read-beat tracker for the SDRAM port arbiter.
// Counts pending beats, flags overflow risk and orphan responses.
module sdram_arb_rd_tracker #(
    parameter int BURST_W     = 8,
    parameter int MAX_PENDING = 64,
    parameter int PEND_W      = $clog2(MAX_PENDING + 1)
) (
    input  logic               sdram_clk,
    input  logic               sdram_rst,
    input  logic               rd_acc_i,
    input  logic [BURST_W-1:0] burst_i,
    input  logic               rdv_i,
    output logic [PEND_W-1:0]  pending_o,
    output logic               blocked_o,
    output logic               err_o
);

    localparam int SUM_W = ((PEND_W > BURST_W) ? PEND_W : BURST_W) + 1;

    logic [PEND_W-1:0] pending_q, pending_d;
    logic              err_q, err_d;
    logic [SUM_W-1:0]  sum;

    assign sum       = SUM_W'(pending_q) + SUM_W'(burst_i);
    assign blocked_o = sum > SUM_W'(MAX_PENDING);
    assign pending_o = pending_q;
    assign err_o     = err_q;

    // Add an accepted burst, retire one beat per response, never underflow.
    always_comb begin
        pending_d = pending_q;
        err_d     = err_q;
        if (rd_acc_i) begin
            pending_d = PEND_W'(sum);
        end
        if (rdv_i) begin
            if (pending_q != '0) begin
                pending_d = pending_d - PEND_W'(1);
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Counter and sticky error register.
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-master arbiter for the shared 256-bit SDRAM Avalon port.
// Writer has priority; reader is protected by a starvation limit.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int DATA_W       = ARB_DATA_W,
    parameter int BURST_W      = ARB_BURST_W,
    parameter int STARVE_LIMIT = 16,
    parameter int MAX_PENDING  = 64,
    parameter int PEND_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic                sdram_clk,
    input  logic                sdram_rst,
    input  logic [ADDR_W-1:0]   w_address,
    input  logic [BURST_W-1:0]  w_burstcount,
    input  logic                w_write,
    input  logic [DATA_W-1:0]   w_writedata,
    input  logic [DATA_W/8-1:0] w_byteenable,
    output logic                w_waitrequest,
    input  logic [ADDR_W-1:0]   r_address,
    input  logic [BURST_W-1:0]  r_burstcount,
    input  logic                r_read,
    output logic                r_waitrequest,
    output logic [DATA_W-1:0]   r_readdata,
    output logic                r_readdatavalid,
    output logic [ADDR_W-1:0]   s_address,
    output logic [BURST_W-1:0]  s_burstcount,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    output logic                s_read,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_readdatavalid,
    output logic [PEND_W-1:0]   pending_beats,
    output logic                err_rdv
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    gnt_t               gnt_q, gnt_d;
    logic [BURST_W-1:0] wleft_q, wleft_d;
    logic [SC_W-1:0]    starve_q, starve_d;

    logic r_blocked, r_req, wr_acc, rd_acc;
    logic in_burst, w_last, w_done, w_idle;

    assign r_readdata      = s_readdata;
    assign r_readdatavalid = s_readdatavalid;

    assign r_req    = r_read & ~r_blocked;
    assign wr_acc   = s_write & ~s_waitrequest;
    assign rd_acc   = s_read & ~s_waitrequest;
    assign in_burst = wleft_q != '0;
    assign w_last   = in_burst ? (wleft_q == BURST_W'(1))
                               : (w_burstcount <= BURST_W'(1));
    assign w_done   = wr_acc & w_last;
    assign w_idle   = ~in_burst & ~w_write;

    sdram_arb_rd_tracker #(
        .BURST_W     (BURST_W),
        .MAX_PENDING (MAX_PENDING),
        .PEND_W      (PEND_W)
    ) u_rd_tracker (
        .sdram_clk (sdram_clk),
        .sdram_rst (sdram_rst),
        .rd_acc_i  (rd_acc),
        .burst_i   (r_burstcount),
        .rdv_i     (s_readdatavalid),
        .pending_o (pending_beats),
        .blocked_o (r_blocked),
        .err_o     (err_rdv)
    );

    // Same-cycle passthrough of the granted master's command.
    always_comb begin
        s_address     = w_address;
        s_burstcount  = w_burstcount;
        s_write       = w_write;
        s_writedata   = w_writedata;
        s_byteenable  = w_byteenable;
        s_read        = 1'b0;
        w_waitrequest = s_waitrequest;
        r_waitrequest = 1'b1;
        if (gnt_q == GNT_R) begin
            s_address     = r_address;
            s_burstcount  = r_burstcount;
            s_write       = 1'b0;
            s_byteenable  = '0;
            s_read        = r_req;
            w_waitrequest = 1'b1;
            r_waitrequest = s_waitrequest | r_blocked;
        end
    end

    // Burst tracking, starvation count and grant decision at boundaries.
    always_comb begin
        gnt_d    = gnt_q;
        wleft_d  = wleft_q;
        starve_d = starve_q;
        if (wr_acc) begin
            if (in_burst) begin
                wleft_d = wleft_q - BURST_W'(1);
            end else if (w_burstcount != '0) begin
                wleft_d = w_burstcount - BURST_W'(1);
            end
        end
        if (w_done && r_read && starve_q != SC_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + SC_W'(1);
        end
        case (gnt_q)
            GNT_W: begin
                if ((w_idle || w_done) && r_req &&
                    (w_idle || starve_d == SC_W'(STARVE_LIMIT))) begin
                    gnt_d    = GNT_R;
                    starve_d = '0;
                end
            end
            GNT_R: begin
                if ((~r_req || rd_acc) && w_write) begin
                    gnt_d = GNT_W;
                end
            end
            default: gnt_d = GNT_W;
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            gnt_q    <= GNT_W;
            wleft_q  <= '0;
            starve_q <= '0;
        end else begin
            gnt_q    <= gnt_d;
            wleft_q  <= wleft_d;
            starve_q <= starve_d;
        end
    end

endmodule
